// File: rtl/dmem_dump_reader.sv
// Sweeps DMem after a run and streams each word to a valid/ready sink; first word valid 3 cycles after Start.
// Backpressure: issue stops once 2 words are buffered or in flight, so the 2-entry FIFO never overflows.
module dmem_dump_reader #(
   parameter int unsigned N_WORDS   = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] ADDR_STEP = 32'd4,
   parameter int unsigned IDX_W     = 5
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   output logic             Busy,
   output logic             Done,
   output logic             MemRead,
   output logic [31:0]      Address,
   input  logic [31:0]      ReadData,
   output logic             DumpValid,
   output logic [31:0]      DumpData,
   output logic [IDX_W-1:0] DumpIndex,
   input  logic             DumpReady
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

   state_t           state_q, state_d;
   logic [31:0]      issue_cnt_q, issue_cnt_d;
   logic [31:0]      pop_cnt_q, pop_cnt_d;
   logic             inflight_q, inflight_d;
   logic [IDX_W-1:0] inflight_idx_q, inflight_idx_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      fifo_dat_q [2];
   logic [31:0]      fifo_dat_d [2];
   logic [IDX_W-1:0] fifo_idx_q [2];
   logic [IDX_W-1:0] fifo_idx_d [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       cnt_q, cnt_d;

   logic             issue;
   logic             push;
   logic             pop;
   logic [2:0]       occ;
   logic [31:0]      issue_addr;

   always_comb begin
      state_d        = state_q;
      issue_cnt_d    = issue_cnt_q;
      pop_cnt_d      = pop_cnt_q;
      inflight_d     = 1'b0;
      inflight_idx_d = inflight_idx_q;
      fifo_dat_d     = fifo_dat_q;
      fifo_idx_d     = fifo_idx_q;
      rd_ptr_d       = rd_ptr_q;
      wr_ptr_d       = wr_ptr_q;
      cnt_d          = cnt_q;

      DumpValid  = (cnt_q != 2'd0);
      DumpData   = fifo_dat_q[rd_ptr_q];
      DumpIndex  = fifo_idx_q[rd_ptr_q];
      pop        = DumpValid & DumpReady;
      push       = inflight_q;
      Busy       = (state_q == S_RUN);
      Done       = (state_q == S_FINISH);

      // Occupancy after this cycle's pop; issuing keeps buffered + in-flight at most 2.
      occ        = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
      issue_addr = BASE_ADDR + issue_cnt_q * ADDR_STEP;
      issue      = (state_q == S_RUN) && (issue_cnt_q < N_WORDS) && (occ < 3'd2);
      MemRead    = issue;
      Address    = issue ? issue_addr : addr_q;
      addr_d     = Address;

      if (issue) begin
         issue_cnt_d    = issue_cnt_q + 32'd1;
         inflight_d     = 1'b1;
         inflight_idx_d = issue_cnt_q[IDX_W-1:0];
      end

      if (push) begin
         fifo_dat_d[wr_ptr_q] = ReadData;
         fifo_idx_d[wr_ptr_q] = inflight_idx_q;
         wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d  = ~rd_ptr_q;
         pop_cnt_d = pop_cnt_q + 32'd1;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               state_d     = S_RUN;
               issue_cnt_d = 32'd0;
               pop_cnt_d   = 32'd0;
            end
         end
         S_RUN: begin
            if (pop && (pop_cnt_q == N_WORDS - 1)) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q        <= S_IDLE;
         issue_cnt_q    <= 32'd0;
         pop_cnt_q      <= 32'd0;
         inflight_q     <= 1'b0;
         inflight_idx_q <= '0;
         addr_q         <= 32'd0;
         fifo_dat_q     <= '{default: '0};
         fifo_idx_q     <= '{default: '0};
         rd_ptr_q       <= 1'b0;
         wr_ptr_q       <= 1'b0;
         cnt_q          <= 2'd0;
      end else begin
         state_q        <= state_d;
         issue_cnt_q    <= issue_cnt_d;
         pop_cnt_q      <= pop_cnt_d;
         inflight_q     <= inflight_d;
         inflight_idx_q <= inflight_idx_d;
         addr_q         <= addr_d;
         fifo_dat_q     <= fifo_dat_d;
         fifo_idx_q     <= fifo_idx_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         cnt_q          <= cnt_d;
      end
   end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed/table-driven bench for dmem_dump_reader with a one-cycle synchronous DMem model.
module tb_dmem_dump_reader;

   localparam int IDX_W = 5;
   localparam int NW    = 32;

   logic             Clk = 1'b0;
   logic             Rst;
   logic             Start;
   logic             Busy;
   logic             Done;
   logic             MemRead;
   logic [31:0]      Address;
   logic [31:0]      ReadData;
   logic             DumpValid;
   logic [31:0]      DumpData;
   logic [IDX_W-1:0] DumpIndex;
   logic             DumpReady;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [NW];

   dmem_dump_reader #(
      .N_WORDS  (NW),
      .BASE_ADDR(32'h0000_0000),
      .ADDR_STEP(32'd4),
      .IDX_W    (IDX_W)
   ) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Start    (Start),
      .Busy     (Busy),
      .Done     (Done),
      .MemRead  (MemRead),
      .Address  (Address),
      .ReadData (ReadData),
      .DumpValid(DumpValid),
      .DumpData (DumpData),
      .DumpIndex(DumpIndex),
      .DumpReady(DumpReady)
   );

   always #5 Clk = ~Clk;

   // DMem model: data appears the cycle after the strobe, garbage otherwise.
   always @(posedge Clk) begin
      if (MemRead) ReadData <= mem[Address[6:2]];
      else         ReadData <= 32'hDEAD_BEEF;
   end

   typedef struct {
      logic        start;
      logic        ready;
      logic        busy;
      logic        done;
      logic        mrd;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] idx;
      logic [31:0] data;
   } vec_t;

   vec_t tbl [38];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      next_cycle();
      Start = 1'b0;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " ctl"}, {28'd0, Busy, Done, MemRead, DumpValid}, 32'd0);
      chk({nm, " addr"}, Address, 32'd0);
      chk({nm, " head"}, {DumpData[31:IDX_W], DumpData[IDX_W-1:0] | DumpIndex}, 32'd0);
   endtask

   // Runs a dump to completion from the current cycle, scoreboarding order, data,
   // head stability under stall and buffered+in-flight occupancy.
   task automatic drain(input string nm, input bit rnd, input int iss0, input int restart_k);
      int          nxt     = 0;
      int          iss     = iss0;
      int          acc     = 0;
      int          ndone   = 0;
      bit          stalled = 1'b0;
      logic [31:0] hd_dat  = '0;
      logic [31:0] hd_idx  = '0;
      for (int k = 0; k < 400 && ndone == 0; k++) begin
         DumpReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         Start     = (k == restart_k);
         @(negedge Clk);
         if (iss - acc > 2) chk($sformatf("%s occupancy k=%0d", nm, k), iss - acc, 32'd2);
         if (stalled) begin
            chk($sformatf("%s stall hold k=%0d", nm, k),
                {31'd0, DumpValid} ^ ({27'd0, DumpIndex} ^ hd_idx) ^ (DumpData ^ hd_dat), 32'd1);
         end
         if (DumpValid && DumpReady) begin
            chk($sformatf("%s idx #%0d", nm, nxt), {27'd0, DumpIndex}, nxt);
            chk($sformatf("%s data #%0d", nm, nxt), DumpData, mem[nxt % NW]);
            nxt++;
         end
         stalled = DumpValid && !DumpReady;
         hd_dat  = DumpData;
         hd_idx  = {27'd0, DumpIndex};
         iss += int'(MemRead);
         acc += int'(DumpValid && DumpReady);
         if (Done) begin
            ndone++;
            chk($sformatf("%s busy at done", nm), {31'd0, Busy}, 32'd0);
         end
         next_cycle();
      end
      Start = 1'b0;
      chk($sformatf("%s done seen", nm), ndone, 32'd1);
      chk($sformatf("%s words", nm), nxt, NW);
      chk($sformatf("%s issues", nm), iss, NW);
   endtask

   initial begin
      int nrd;
      for (int i = 0; i < NW; i++) mem[i] = 32'hA5A5_0000 + i;
      Rst       = 1'b0;
      Start     = 1'b0;
      DumpReady = 1'b0;

      // Reset held, then idle with Start low.
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         chk_all_zero($sformatf("rst c%0d", c));
         next_cycle();
      end
      Rst = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge Clk);
         chk_all_zero($sformatf("idle c%0d", c));
         next_cycle();
      end

      // Full dump with ready high; Start held through FINISH re-triggers.
      for (int c = 0; c < 38; c++) begin
         tbl[c].start = (c == 0) || (c == 35) || (c == 36);
         tbl[c].ready = 1'b1;
         tbl[c].busy  = (c >= 1 && c <= 34) || (c == 37);
         tbl[c].done  = (c == 35);
         tbl[c].mrd   = (c >= 1 && c <= 32) || (c == 37);
         tbl[c].addr  = (c >= 1 && c <= 32) ? 32'((c - 1) * 4) :
                        (c >= 33 && c <= 36) ? 32'd124 : 32'd0;
         tbl[c].vld   = (c >= 3 && c <= 34);
         tbl[c].idx   = 32'(c - 3);
         tbl[c].data  = 32'hA5A5_0000 + 32'(c - 3);
      end
      for (int c = 0; c < 38; c++) begin
         Start     = tbl[c].start;
         DumpReady = tbl[c].ready;
         @(negedge Clk);
         chk($sformatf("full c%0d busy", c), {31'd0, Busy}, {31'd0, tbl[c].busy});
         chk($sformatf("full c%0d done", c), {31'd0, Done}, {31'd0, tbl[c].done});
         chk($sformatf("full c%0d mrd", c), {31'd0, MemRead}, {31'd0, tbl[c].mrd});
         chk($sformatf("full c%0d addr", c), Address, tbl[c].addr);
         chk($sformatf("full c%0d vld", c), {31'd0, DumpValid}, {31'd0, tbl[c].vld});
         if (tbl[c].vld) begin
            chk($sformatf("full c%0d idx", c), {27'd0, DumpIndex}, tbl[c].idx);
            chk($sformatf("full c%0d data", c), DumpData, tbl[c].data);
         end
         next_cycle();
      end
      Start = 1'b0;
      drain("retrig", 1'b0, 1, -1);

      // Pseudo-random backpressure.
      pulse_start();
      drain("bp", 1'b1, 0, -1);

      // Long stall: ready low cycles 2..19, released at cycle 20.
      nrd = 0;
      Start = 1'b1;
      DumpReady = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c == 1) Start = 1'b0;
         if (c == 2) DumpReady = 1'b0;
         @(negedge Clk);
         nrd += int'(MemRead);
         if (c >= 3) begin
            chk($sformatf("stall c%0d head", c),
                {DumpValid, 26'd0, DumpIndex} ^ DumpData, 32'h8000_0000 ^ mem[0]);
         end
         next_cycle();
      end
      chk("stall memread pulses", nrd, 32'd2);
      drain("stall", 1'b0, 2, -1);

      // Start again at cycle 10 is ignored.
      pulse_start();
      drain("sbusy", 1'b0, 0, 9);
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         chk($sformatf("sbusy after c%0d", c), {30'd0, Busy, Done}, 32'd0);
         next_cycle();
      end

      // Reset mid-dump with a read in flight.
      pulse_start();
      DumpReady = 1'b1;
      for (int c = 1; c < 15; c++) next_cycle();
      @(negedge Clk);
      chk("mid read in flight", {31'd0, MemRead}, 32'd1);
      Rst = 1'b0;
      next_cycle();
      Rst = 1'b1;
      @(negedge Clk);
      chk_all_zero("mid after rst");
      next_cycle();
      for (int c = 0; c < 5; c++) begin
         @(negedge Clk);
         chk($sformatf("mid quiet c%0d", c), {29'd0, Busy, Done, DumpValid}, 32'd0);
         next_cycle();
      end
      pulse_start();
      drain("fresh", 1'b0, 0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
